// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the PIC interrupt-acknowledge logic.
//   state_t       - handshake sequencer states
//   LVL_W         - width of a request level index
//   SPURIOUS_LVL  - level reported when an INTA finds nothing to acknowledge
//   rank_of()     - priority rank of a level given the lowest-priority pointer
package pic_pkg;

  localparam int LVL_W = 3;
  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2,
    VEC  = 2'd3
  } state_t;

  // Rank 0 is the level just above lp; wraps modulo 8 through 3-bit arithmetic.
  function automatic logic [LVL_W-1:0] rank_of(input logic [LVL_W-1:0] lvl,
                                               input logic [LVL_W-1:0] lp);
    return lvl - lp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// pic_inta_sequencer_if: CPU-side interrupt handshake bus.
//   inta    - one-cycle strobe per CPU INTA pulse (CPU -> PIC)
//   int_out - interrupt request to the CPU       (PIC -> CPU)
//   dout    - vector byte                         (PIC -> CPU)
//   dout_en - vector valid / bus drive enable     (PIC -> CPU)
// master: CPU side, slave: PIC side.
interface pic_inta_sequencer_if;
  logic       inta;
  logic       int_out;
  logic [7:0] dout;
  logic       dout_en;

  modport master (output inta, input int_out, input dout, input dout_en);
  modport slave  (input inta, output int_out, output dout, output dout_en);
endinterface

// File: rtl/pic_prio_rank.sv
// pic_prio_rank: rotating priority encoder.
//   req   in 8  - request vector, bit i is level i
//   lp    in 3  - lowest-priority level; level lp+1 is searched first
//   valid out 1 - at least one bit of req is set
//   level out 3 - highest-ranked set level (0 when valid is low)
module pic_prio_rank
  import pic_pkg::*;
(
  input  logic [7:0]       req,
  input  logic [LVL_W-1:0] lp,
  output logic             valid,
  output logic [LVL_W-1:0] level
);

  logic [LVL_W-1:0] idx;
  logic             hit;

  // Scan from lowest rank to highest so the highest-ranked hit is written last.
  always_comb begin
    valid = 1'b0;
    level = 3'd0;
    idx   = 3'd0;
    hit   = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      idx   = lp + 3'd1 + 3'(k);
      hit   = req[idx];
      valid = valid | hit;
      level = hit ? idx : level;
    end
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: interrupt-acknowledge side of the PIC.
// Resolves the winning request against the in-service register, raises
// int_out, runs the two-strobe INTA handshake, and owns the ISR, EOI handling
// (specific, non-specific, automatic) and priority rotation.
//   clk, rst           - clock, synchronous active-high reset
//   irr      in 8      - masked pending requests
//   irr_clr  out 8     - one-cycle one-hot clear of the acknowledged IRR bit
//   vec_base in 5      - upper five vector bits
//   aeoi, rotate in 1  - automatic EOI mode, rotate-on-EOI mode
//   eoi, seoi in 1     - non-specific / specific EOI strobes
//   seoi_lvl in 3      - level targeted by seoi
//   isr      out 8     - in-service register
//   bus                - CPU handshake (inta, int_out, dout, dout_en)
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int N_IRQ          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IRQ-1:0]     irr,
  output logic [N_IRQ-1:0]     irr_clr,
  input  logic [4:0]           vec_base,
  input  logic                 aeoi,
  input  logic                 rotate,
  input  logic                 eoi,
  input  logic                 seoi,
  input  logic [LVL_W-1:0]     seoi_lvl,
  output logic [N_IRQ-1:0]     isr,
  pic_inta_sequencer_if.slave  bus
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t           state_r, state_s;
  logic [LVL_W-1:0] lp_r, lp_s;
  logic [LVL_W-1:0] lvl_r, lvl_s;
  logic             spur_r, spur_s;
  logic [7:0]       tmo_r, tmo_s;
  logic [7:0]       isr_r, isr_s;
  logic [7:0]       irr_clr_r, irr_clr_s;
  logic [7:0]       dout_r, dout_s;
  logic             dout_en_r, dout_en_s;
  logic             int_out_r, int_out_s;

  logic             irr_vld_s, isr_vld_s;
  logic [LVL_W-1:0] irr_lvl_s, isr_lvl_s;
  logic             qual_s;

  pic_prio_rank u_irr_rank (
    .req   (irr),
    .lp    (lp_r),
    .valid (irr_vld_s),
    .level (irr_lvl_s)
  );

  pic_prio_rank u_isr_rank (
    .req   (isr_r),
    .lp    (lp_r),
    .valid (isr_vld_s),
    .level (isr_lvl_s)
  );

  // Fully nested: the best request must outrank every level already in service.
  assign qual_s = irr_vld_s &
                  (~isr_vld_s | (rank_of(irr_lvl_s, lp_r) < rank_of(isr_lvl_s, lp_r)));

  // Next-state, ISR/rotation update and registered-output values.
  always_comb begin
    state_s   = state_r;
    lp_s      = lp_r;
    lvl_s     = lvl_r;
    spur_s    = spur_r;
    tmo_s     = tmo_r;
    isr_s     = isr_r;
    irr_clr_s = 8'd0;
    dout_s    = 8'd0;
    dout_en_s = 1'b0;
    int_out_s = 1'b0;

    // EOI clears are applied before any same-cycle ISR set below.
    if (seoi) begin
      isr_s[seoi_lvl] = 1'b0;
    end else if (eoi && isr_vld_s) begin
      isr_s[isr_lvl_s] = 1'b0;
      lp_s = rotate ? isr_lvl_s : lp_r;
    end else begin
      lp_s = lp_r;
    end

    case (state_r)
      IDLE, REQ: begin
        if (bus.inta) begin
          state_s = ACK1;
          tmo_s   = 8'd0;
          if (qual_s) begin
            lvl_s            = irr_lvl_s;
            spur_s           = 1'b0;
            isr_s[irr_lvl_s] = 1'b1;
            irr_clr_s        = 8'd1 << irr_lvl_s;
          end else begin
            lvl_s  = SPURIOUS_LVL;
            spur_s = 1'b1;
          end
        end else if (qual_s) begin
          state_s   = REQ;
          int_out_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACK1: begin
        if (bus.inta) begin
          state_s   = VEC;
          dout_s    = {vec_base, lvl_r};
          dout_en_s = 1'b1;
          if (aeoi && !spur_r) begin
            isr_s[lvl_r] = 1'b0;
            lp_s = rotate ? lvl_r : lp_s;
          end else begin
            lp_s = lp_s;
          end
        end else if (tmo_r == TMO_LIMIT) begin
          state_s = IDLE;
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      VEC: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      lp_r      <= 3'd7;
      lvl_r     <= 3'd0;
      spur_r    <= 1'b0;
      tmo_r     <= 8'd0;
      isr_r     <= 8'd0;
      irr_clr_r <= 8'd0;
      dout_r    <= 8'd0;
      dout_en_r <= 1'b0;
      int_out_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      lp_r      <= lp_s;
      lvl_r     <= lvl_s;
      spur_r    <= spur_s;
      tmo_r     <= tmo_s;
      isr_r     <= isr_s;
      irr_clr_r <= irr_clr_s;
      dout_r    <= dout_s;
      dout_en_r <= dout_en_s;
      int_out_r <= int_out_s;
    end
  end

  assign isr         = isr_r;
  assign irr_clr     = irr_clr_r;
  assign bus.int_out = int_out_r;
  assign bus.dout    = dout_r;
  assign bus.dout_en = dout_en_r;

endmodule

// File: doc/pic_inta_sequencer.md
# pic_inta_sequencer

Interrupt-acknowledge side of the PIC. Takes the masked request levels, resolves the winning level against the in-service register, raises `int_out` to the CPU and runs the two-pulse INTA handshake. Over that handshake it sets the ISR bit, clears the IRR bit and drives the 8-bit vector. It owns the ISR, end-of-interrupt handling (specific, non-specific, automatic) and priority rotation.

## Interface
Parameters:
- `N_IRQ`, 8: number of request levels; only 8 is supported.
- `TIMEOUT_CYCLES`, 255: cycles allowed between the two INTA strobes before the sequence aborts.

Ports:
- `clk` in 1: single system clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `irr` in 8: masked pending requests (`irr & ~imr`); bit i is level i.
- `irr_clr` out 8: one-cycle one-hot pulse clearing the acknowledged IRR bit.
- `vec_base` in 5: ICW2[7:3].
- `aeoi` in 1: automatic-EOI mode.
- `rotate` in 1: rotate priority on EOI.
- `eoi` in 1: one-cycle non-specific EOI strobe.
- `seoi` in 1: one-cycle specific EOI strobe.
- `seoi_lvl` in 3: level targeted by `seoi`.
- `inta` in 1: one-cycle strobe per CPU INTA pulse, already synchronized.
- `int_out` out 1: interrupt request to the CPU.
- `dout` out 8: vector byte.
- `dout_en` out 1: vector valid / bus drive enable.
- `isr` out 8: in-service register.

## Operation
- **Reset values:**
  - `int_out`=0, `dout`=0, `dout_en`=0, `irr_clr`=0, `isr`=0.
  - Lowest-priority pointer `lp`=7, so level 0 is highest.
  - State IDLE.
- **Priority:** level `(lp+1+k) mod 8` has rank k, where rank 0 is highest. With `rotate`=0, `lp` stays 7 (fixed priority).
- **Qualification (fully nested):** the highest-rank `irr` bit qualifies only if its rank is strictly below the rank of every set `isr` bit.
- **States:**
  - IDLE → REQ when a level qualifies; `int_out`=1.
  - REQ → ACK1 on `inta`.
    - The winning level L is latched from the same-cycle `irr`.
    - `isr[L]` is set and `irr_clr[L]` is pulsed; `int_out`=0.
    - If no level qualifies at that strobe, L=7 is latched as spurious: no ISR set, no `irr_clr`.
  - IDLE → ACK1 on `inta` with no pending request: treated as spurious, L=7.
  - ACK1 → VEC on the second `inta`.
    - `dout`={`vec_base`,L}, `dout_en`=1.
    - If `aeoi` and the level is not spurious, `isr[L]` clears on this edge. If `rotate`=1, `lp`:=L.
  - VEC → IDLE after one cycle.
  - ACK1 → IDLE when the timeout counter reaches `TIMEOUT_CYCLES` with no second strobe; ISR is left unchanged.
- **Non-specific EOI:** clears the highest-rank set `isr` bit H. If `rotate`=1, `lp`:=H. No-op when `isr`=0.
- **Specific EOI:** clears `isr[seoi_lvl]`. Never rotates.
- **Simultaneous EOI and INTA set in one cycle:** the clear is applied first, then the set.
- **Simultaneous `eoi` and `seoi`:** `seoi` wins.
- **Request withdrawn in REQ:** `int_out` drops the next cycle and the state returns to IDLE, unless `inta` arrives in that same cycle.
- **Reset mid-handshake:** returns to the reset values on the next edge, with no vector and no `irr_clr` pulse.

## Timing
- `irr` qualifying at edge n → `int_out`=1 after edge n+1.
- First `inta` at edge n → `isr`, `irr_clr` and `int_out`=0 visible after edge n; `irr_clr` is high for exactly one cycle.
- Second `inta` at edge m → `dout`/`dout_en` valid for the single cycle after edge m.
- `inta` strobes in VEC are ignored.
- Minimum spacing of the two strobes is one cycle.
- Timeout counter is 8 bits; it counts from the first strobe and resets on each entry to ACK1.

## Structure
- Shared package `pic_pkg`:
  - State enum (IDLE, REQ, ACK1, VEC).
  - `SPURIOUS_LVL`=7.
  - Level width 3.
- One sub-module: `pic_prio_rank`.
  - Combinational rotate-by-`lp` priority encoder returning `{valid, level}`.
  - Instantiated twice: for `irr` and for `isr`.

## Test plan
- **Basic handshake:** `irr`=0x24, `vec_base`=5'h08, two `inta` strobes → `int_out` rises; `isr`=0x04, `irr_clr`=0x04; `dout`=0x42.
- **Nesting:** with `isr`=0x04, `irr`=0x08 → `int_out` stays 0; `irr`=0x01 → `int_out`=1.
- **AEOI with rotation:** `aeoi`=1, `rotate`=1, `irr`=0x01, handshake → `isr`=0 after the second strobe; `lp`=0; then `irr`=0x03 → vector level 1.
- **Non-specific EOI and rotation:** `isr`=0x0A, `rotate`=1, `eoi` → `isr`=0x08, `lp`=1.
- **Spurious:** `irr` drops in the same cycle as the first `inta` → `dout`={`vec_base`,3'd7}; `isr` and `irr_clr` unchanged.
- **Timeout and reset:** no second `inta` for 255 cycles → IDLE, `dout_en` never asserted; `rst` in ACK1 → all outputs return to their reset values.
